// File: rtl/egg_timer_ctrl.sv
// Egg-timer control FSM: setpoint entry, countdown sequencing and alarm.
// Define EGG_TIMER_ALARM_BLINK_EN to make LED_on toggle on each tick_1hz during ALARM.
module egg_timer_ctrl #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cook_time,
  input  logic        start,
  input  logic        mins_btn,
  input  logic        secs_btn,
  input  logic        tick_1hz,
  input  logic        count_zero,
  output logic        load,
  output logic [11:0] load_val,
  output logic        dec,
  output logic [5:0]  set_min,
  output logic [5:0]  set_sec,
  output logic [2:0]  state_out,
  output logic        LED_on,
  output logic        LED_en
);

  localparam int unsigned FIELD_W = 6;
  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0]   ALARM_LAST = CNT_W'(ALARM_SECS - 1);
  localparam logic [FIELD_W-1:0] FIELD_MAX  = FIELD_W'(59);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    ALARM = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   alarm_cnt;
  logic [FIELD_W-1:0] min_nxt;
  logic [FIELD_W-1:0] sec_nxt;
  logic               setpoint_zero;

  // Setpoint after this cycle's button presses; buttons only count in SETUP.
  always_comb begin
    min_nxt = set_min;
    sec_nxt = set_sec;
    if (state == SETUP) begin
      if (mins_btn) min_nxt = (set_min == FIELD_MAX) ? '0 : set_min + FIELD_W'(1);
      if (secs_btn) sec_nxt = (set_sec == FIELD_MAX) ? '0 : set_sec + FIELD_W'(1);
    end
  end

  assign setpoint_zero = (set_min == '0) && (set_sec == '0);
  assign dec           = !rst && (state == RUN) && tick_1hz && enable && !count_zero;
  assign state_out     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      set_min   <= '0;
      set_sec   <= '0;
      load_val  <= '0;
      alarm_cnt <= '0;
      load      <= 1'b0;
      LED_on    <= 1'b0;
      LED_en    <= 1'b0;
    end else begin
      load    <= 1'b0;
      set_min <= min_nxt;
      set_sec <= sec_nxt;
      // load_val always mirrors the registered setpoint, so it is valid whenever load is.
      load_val <= 12'(min_nxt) * 12'd60 + 12'(sec_nxt);
      if (cook_time) begin
        state     <= SETUP;
        alarm_cnt <= '0;
        LED_on    <= 1'b0;
        LED_en    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !setpoint_zero) begin
              load  <= 1'b1;
              state <= READY;
            end
          end
          SETUP: begin
            load  <= 1'b1;
            state <= READY;
          end
          READY: begin
            if (start && enable && !count_zero) begin
              state  <= RUN;
              LED_en <= 1'b1;
            end
          end
          RUN: begin
            if (count_zero) begin
              state     <= ALARM;
              alarm_cnt <= '0;
              LED_on    <= 1'b1;
              LED_en    <= 1'b0;
            end else if (start || !enable) begin
              state  <= READY;
              LED_en <= 1'b0;
            end
          end
          ALARM: begin
            if (start) begin
              state     <= IDLE;
              alarm_cnt <= '0;
              LED_on    <= 1'b0;
            end else if (tick_1hz) begin
              if (alarm_cnt == ALARM_LAST) begin
                state     <= IDLE;
                alarm_cnt <= '0;
                LED_on    <= 1'b0;
              end else begin
                alarm_cnt <= alarm_cnt + CNT_W'(1);
`ifdef EGG_TIMER_ALARM_BLINK_EN
                LED_on <= !LED_on;
`else
                LED_on <= 1'b1;
`endif
              end
            end
          end
          default: begin
            state     <= IDLE;
            alarm_cnt <= '0;
            LED_on    <= 1'b0;
            LED_en    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl: behavioural model compared every cycle plus literal pins.
module tb_egg_timer_ctrl;

  localparam int unsigned ALARM_SECS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic cook_time = 1'b0;
  logic start = 1'b0;
  logic mins_btn = 1'b0;
  logic secs_btn = 1'b0;
  logic tick_1hz = 1'b0;
  logic count_zero = 1'b0;
  logic        load;
  logic [11:0] load_val;
  logic        dec;
  logic [5:0]  set_min;
  logic [5:0]  set_sec;
  logic [2:0]  state_out;
  logic        LED_on;
  logic        LED_en;

  always #5 clk = ~clk;

  egg_timer_ctrl #(.ALARM_SECS(ALARM_SECS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cook_time(cook_time), .start(start),
    .mins_btn(mins_btn), .secs_btn(secs_btn), .tick_1hz(tick_1hz), .count_zero(count_zero),
    .load(load), .load_val(load_val), .dec(dec), .set_min(set_min), .set_sec(set_sec),
    .state_out(state_out), .LED_on(LED_on), .LED_en(LED_en)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int dec_seen = 0;

  // Model: state as a number (0 idle,1 setup,2 ready,3 run,4 alarm), setpoint in min/sec.
  int m_state = 0;
  int m_min = 0;
  int m_sec = 0;
  int m_ticks = 0;
  bit m_load = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_min = 0; m_sec = 0; m_ticks = 0; m_load = 1'b0;
    end else begin
      m_load = 1'b0;
      if (m_state == 1) begin
        m_min = (m_min + int'(mins_btn)) % 60;
        m_sec = (m_sec + int'(secs_btn)) % 60;
      end
      if (cook_time) m_state = 1;
      else begin
        case (m_state)
          0: if (start && (m_min * 60 + m_sec) != 0) begin m_load = 1'b1; m_state = 2; end
          1: begin m_load = 1'b1; m_state = 2; end
          2: if (start && enable && !count_zero) m_state = 3;
          3: if (count_zero) begin m_state = 4; m_ticks = 0; end
             else if (start || !enable) m_state = 2;
          4: if (start) m_state = 0;
             else if (tick_1hz) begin
               m_ticks++;
               if (m_ticks == ALARM_SECS) m_state = 0;
             end
          default: m_state = 0;
        endcase
      end
    end
  end

  function automatic bit exp_led();
    if (m_state != 4) return 1'b0;
`ifdef EGG_TIMER_ALARM_BLINK_EN
    return (m_ticks % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state_out), 32'(m_state));
      chk("set_min", 32'(set_min), 32'(m_min));
      chk("set_sec", 32'(set_sec), 32'(m_sec));
      chk("load", 32'(load), 32'(m_load));
      chk("load_val", 32'(load_val), 32'(m_min * 60 + m_sec));
      chk("LED_on", 32'(LED_on), 32'(exp_led()));
      chk("LED_en", 32'(LED_en), 32'(m_state == 3));
      chk("dec", 32'(dec), 32'(!rst && m_state == 3 && tick_1hz && enable && !count_zero));
      if (dec === 1'b1) dec_seen++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic press_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask
  task automatic press_mins();
    mins_btn = 1'b1; cyc(); mins_btn = 1'b0;
  endtask
  task automatic press_secs();
    secs_btn = 1'b1; cyc(); secs_btn = 1'b0;
  endtask
  task automatic tick_pulse();
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    chk_en = 1'b1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_led", 32'({LED_on, LED_en}), 32'd0);
    cyc();
    rst = 1'b0;

    // Setpoint entry 2:30 then leave SETUP
    cook_time = 1'b1; cyc();
    repeat (2) press_mins();
    repeat (30) press_secs();
    cook_time = 1'b0; cyc();
    chk("entry_load", 32'(load), 32'd1);
    chk("entry_val", 32'(load_val), 32'd150);
    chk("entry_state", 32'(state_out), 32'd2);
    cyc();
    chk("entry_load_once", 32'(load), 32'd0);

    // Simultaneous buttons with seconds at 59
    cook_time = 1'b1; cyc();
    repeat (29) press_secs();
    chk("sec59", 32'(set_sec), 32'd59);
    mins_btn = 1'b1; secs_btn = 1'b1; cyc(); mins_btn = 1'b0; secs_btn = 1'b0;
    chk("both_min", 32'(set_min), 32'd3);
    chk("both_sec", 32'(set_sec), 32'd0);
    cook_time = 1'b0; cyc();
    chk("val180", 32'(load_val), 32'd180);
    cyc();

    // Run, pause, resume
    press_start();
    chk("run_state", 32'(state_out), 32'd3);
    chk("run_led_en", 32'(LED_en), 32'd1);
    dec_seen = 0;
    repeat (3) tick_pulse();
    chk("dec_three", 32'(dec_seen), 32'd3);
    press_start();
    chk("pause_state", 32'(state_out), 32'd2);
    dec_seen = 0;
    repeat (2) tick_pulse();
    chk("dec_paused", 32'(dec_seen), 32'd0);
    press_start();
    chk("resume_state", 32'(state_out), 32'd3);

    // Enable drop at a tick
    enable = 1'b0; tick_1hz = 1'b1; #2;
    chk("dec_en_low", 32'(dec), 32'd0);
    @(posedge clk); #1; tick_1hz = 1'b0;
    chk("en_low_state", 32'(state_out), 32'd2);
    press_start();
    chk("start_en_low", 32'(state_out), 32'd2);
    enable = 1'b1;

    // Alarm timeout
    press_start();
    count_zero = 1'b1; cyc(); count_zero = 1'b0;
    chk("alarm_state", 32'(state_out), 32'd4);
    chk("alarm_led", 32'(LED_on), 32'd1);
    tick_pulse();
`ifdef EGG_TIMER_ALARM_BLINK_EN
    chk("alarm_led_t1", 32'(LED_on), 32'd0);
`else
    chk("alarm_led_t1", 32'(LED_on), 32'd1);
`endif
    repeat (8) tick_pulse();
    chk("alarm_t9_state", 32'(state_out), 32'd4);
    tick_pulse();
    chk("alarm_end_state", 32'(state_out), 32'd0);
    chk("alarm_end_led", 32'(LED_on), 32'd0);

    // Re-arm from IDLE with persisted setpoint, then start exits ALARM
    press_start();
    chk("rearm_load", 32'(load), 32'd1);
    chk("rearm_val", 32'(load_val), 32'd180);
    press_start();
    count_zero = 1'b1; cyc(); count_zero = 1'b0;
    press_start();
    chk("alarm_ack", 32'(state_out), 32'd0);

    // Buttons ignored outside SETUP
    press_mins(); press_secs();
    chk("btn_ignored", 32'({set_min, set_sec}), 32'({6'd3, 6'd0}));

    // cook_time beats start in READY
    press_start();
    cook_time = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    chk("cook_prio", 32'(state_out), 32'd1);
    cook_time = 1'b0; cyc();

    // Reset mid-RUN
    press_start();
    tick_pulse();
    rst = 1'b1; tick_1hz = 1'b1; #2;
    chk("dec_in_rst", 32'(dec), 32'd0);
    @(posedge clk); #1; tick_1hz = 1'b0;
    chk("rst_run_state", 32'(state_out), 32'd0);
    chk("rst_run_set", 32'({set_min, set_sec}), 32'd0);
    chk("rst_run_led_en", 32'(LED_en), 32'd0);
    rst = 1'b0;
    press_start();
    chk("zero_start", 32'(state_out), 32'd0);
    chk("zero_start_load", 32'(load), 32'd0);

    // Reset mid-ALARM
    cook_time = 1'b1; cyc(); press_mins(); cook_time = 1'b0; cyc();
    press_start();
    count_zero = 1'b1; cyc(); count_zero = 1'b0;
    tick_pulse();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_alarm_state", 32'(state_out), 32'd0);
    chk("rst_alarm_led", 32'(LED_on), 32'd0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
